// File: rtl/guess_checker.sv
// guess_checker: BCD number-guessing round controller (ENTRY/WAIT/CHECK/RESULT/DONE).
// Define ATTEMPT_LIMIT_EN to add the per-round attempt limit and the missed output.
module guess_checker #(
  parameter int MAX_ATTEMPTS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_in,
  input  logic       digit_enter,
  input  logic       submit,
  input  logic       clear,
  input  logic [3:0] target_digit_1,
  input  logic [3:0] target_digit_2,
  input  logic [3:0] target_digit_3,
  output logic [3:0] round,
  output logic [1:0] Max_digit,
  output logic [3:0] guess_digit_1,
  output logic [3:0] guess_digit_2,
  output logic [3:0] guess_digit_3,
  output logic       too_high,
  output logic       too_low,
  output logic       correct,
  output logic [3:0] attempts,
  output logic       game_over
`ifdef ATTEMPT_LIMIT_EN
  ,
  output logic       missed
`endif
);
  typedef enum logic [2:0] {ENTRY, WAIT, CHECK, RESULT, DONE} state_t;
  if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 15) begin : g_bad_max
    $error("MAX_ATTEMPTS must be within 1..15");
  end
  state_t state_q, state_d;
  logic [3:0] round_q, round_d, g1_q, g1_d, g2_q, g2_d, g3_q, g3_d, att_q, att_d, att_inc;
  logic [1:0] md_q, md_d;
  logic th_q, th_d, tl_q, tl_d, co_q, co_d, go_q, go_d, lim;
  logic [11:0] guess_w, target_w;
  assign guess_w = {g3_q, g2_q, g1_q};
  assign target_w = {target_digit_3, target_digit_2, target_digit_1};
  assign att_inc = (att_q == 4'hf) ? 4'hf : att_q + 4'd1;
`ifdef ATTEMPT_LIMIT_EN
  logic miss_q;
  assign lim = !co_q && att_inc == 4'(MAX_ATTEMPTS);
  assign missed = miss_q;
`else
  assign lim = 1'b0;
`endif
  assign md_d = (round_d <= 4'd3) ? 2'd1 : (round_d <= 4'd6) ? 2'd2 : 2'd3;
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    g1_d = g1_q;
    g2_d = g2_q;
    g3_d = g3_q;
    th_d = th_q;
    tl_d = tl_q;
    co_d = co_q;
    att_d = att_q;
    go_d = go_q;
    case (state_q)
      ENTRY:
        if (clear) begin
          {g3_d, g2_d, g1_d} = 12'd0;
          {th_d, tl_d, co_d} = 3'b000;
        end else if (submit) begin
          state_d = WAIT;
        end else if (digit_enter && digit_in <= 4'd9) begin
          g1_d = digit_in;
          g2_d = (md_q >= 2'd2) ? g1_q : 4'd0;
          g3_d = (md_q == 2'd3) ? g2_q : 4'd0;
        end
      WAIT: state_d = CHECK;
      CHECK: begin
        th_d = guess_w > target_w;
        tl_d = guess_w < target_w;
        co_d = guess_w == target_w;
        state_d = RESULT;
      end
      RESULT:
        // a correct guess and a limit-reaching miss both finish the round
        if (co_q || lim) begin
          state_d = (round_q == 4'd9) ? DONE : ENTRY;
          go_d = round_q == 4'd9;
          if (round_q != 4'd9) begin
            round_d = round_q + 4'd1;
            {g3_d, g2_d, g1_d} = 12'd0;
            att_d = 4'd0;
          end
        end else begin
          att_d = att_inc;
          state_d = ENTRY;
        end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ENTRY;
      round_q <= 4'd1;
      md_q <= 2'd1;
      {g3_q, g2_q, g1_q} <= 12'd0;
      {th_q, tl_q, co_q} <= 3'b000;
      att_q <= 4'd0;
      go_q <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      md_q <= md_d;
      {g3_q, g2_q, g1_q} <= {g3_d, g2_d, g1_d};
      {th_q, tl_q, co_q} <= {th_d, tl_d, co_d};
      att_q <= att_d;
      go_q <= go_d;
    end
  end
`ifdef ATTEMPT_LIMIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) miss_q <= 1'b0;
    else miss_q <= state_q == RESULT && lim;
  end
`endif
  assign round = round_q;
  assign Max_digit = md_q;
  assign guess_digit_1 = g1_q;
  assign guess_digit_2 = g2_q;
  assign guess_digit_3 = g3_q;
  assign too_high = th_q;
  assign too_low = tl_q;
  assign correct = co_q;
  assign attempts = att_q;
  assign game_over = go_q;
endmodule
